// File: rtl/uart_byte_receiver.sv
// 8N1 serial byte receiver with two-flop synchroniser and single-cycle result pulses.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1, selected by PARITY_ODD).
module uart_byte_receiver #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic             rx_meta_q, rx_s_q, rx_d_q;
    logic [1:0]       flush_q, flush_d;
    logic             armed_q, armed_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             busy_q, busy_d;
    logic             start_edge, sample, parity_bad;

    // Only arm edge detection once the synchroniser holds a real high from the line,
    // so a line still low when reset releases never looks like a start bit.
    always_comb begin
        flush_d = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
        armed_d = armed_q | ((flush_q == 2'd2) & rx_s_q);
    end

    assign start_edge = armed_q & rx_d_q & ~rx_s_q;
    assign sample     = (state_q == S_START) ? (bit_cnt_q == CNT_MID) : (bit_cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    assign parity_bad = par_bit_q ^ (^shift_q) ^ PARITY_ODD;
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_START;
            end
            S_START: begin
                if (sample) begin
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample) begin
                    par_bit_d = rx_s_q;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        if (parity_bad) begin
                            parity_err_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (sample || (state_d != state_q) || (state_q == S_IDLE) || (state_q == S_WAIT))
            bit_cnt_d = '0;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_d_q       <= 1'b1;
            flush_q      <= 2'd0;
            armed_q      <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q    <= uart_rx;
            rx_s_q       <= rx_meta_q;
            rx_d_q       <= rx_s_q;
            flush_q      <= flush_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_bit_q <= 1'b0;
        else        par_bit_q <= par_bit_d;
    end
`endif

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_busy       = busy_q;
endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed and randomized frames against a byte-level model of the serial receiver.
// Follows UART_RX_PARITY_EN the same way the design does.
module tb_uart_byte_receiver;
    localparam int CLK_FREQ = 25_000_000;
    localparam int BAUD     = 115200;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int HALF     = DIV / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ODD  = 1'b0;
    localparam int NBITS    = 11;
`else
    localparam int NBITS    = 10;
`endif
    localparam int LAT_NOM  = 2 + 1 + HALF + (NBITS - 1) * DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_parity_err, o_busy;

    uart_byte_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         fe_cnt = 0, pe_cnt = 0, overlap_cnt = 0;
    int         last_valid_cyc = 0, prev_valid_cyc = 0;
    int         fall_cyc = 0;

    // Observe result pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && o_frame_err) overlap_cnt++;
            if (o_valid) begin
                got_q.push_back(o_data);
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
            if (o_frame_err)  fe_cnt++;
            if (o_parity_err) pe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic par_v, input logic stop_v);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v);
`endif
        drive_bit(stop_v);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
`ifdef UART_RX_PARITY_EN
        send_bits(b, (^b) ^ PAR_ODD, stop_v);
`else
        send_bits(b, 1'b0, stop_v);
`endif
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Match every expected byte against an observed pulse, then insist on no extras.
    task automatic drain(input string tag);
        int budget;
        bit done;
        done = 0;
        while (exp_q.size() > 0 && !done) begin
            budget = 4 * DIV;
            while (got_q.size() == 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (got_q.size() == 0) begin
                check({tag, "_timeout"}, got_q.size(), 1);
                exp_q.delete();
                done = 1;
            end else begin
                check(tag, got_q.pop_front(), exp_q.pop_front());
            end
        end
        check({tag, "_extra"}, got_q.size(), 0);
    endtask

    initial begin
        logic [7:0] last_good;
        logic [7:0] b81;
        int         fe_exp, pe_exp, lat, t0, hold;
        logic [7:0] rb;
        bit         bad;

        fe_exp = 0;
        pe_exp = 0;
        last_good = 8'h00;

        repeat (5) @(negedge clk);
        check("reset_outputs", {o_data, o_valid, o_frame_err, o_parity_err, o_busy}, 12'h000);
        rst_n = 1'b1;
        idle(2 * DIV);

        // Single good byte with latency measurement.
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(DIV);
        lat = last_valid_cyc - fall_cyc;
        drain("t1_byte");
        check("t1_latency_window", (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2), 1);
        last_good = 8'h5A;
        check("t1_data_held", o_data, last_good);
        check("t1_no_frame_err", fe_cnt, fe_exp);

        // Short low glitch is rejected at the start-bit mid-sample.
        t0 = cyc;
        uart_rx = 1'b0;
        repeat (50) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t2_busy_during_start", o_busy, 1);
        while (cyc < t0 + HALF + 8) @(negedge clk);
        check("t2_busy_released", o_busy, 0);
        check("t2_no_valid", got_q.size(), 0);
        check("t2_no_frame_err", fe_cnt, fe_exp);

        // Bad stop bit followed by a held-low (break) line.
        send_frame(8'hA3, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        fe_exp++;
        check("t3_frame_err", fe_cnt, fe_exp);
        check("t3_busy_in_break", o_busy, 1);
        check("t3_data_kept", o_data, last_good);
        check("t3_no_valid", got_q.size(), 0);
        idle(6);
        check("t3_busy_after_high", o_busy, 0);
        idle(DIV);

        // Two frames with zero idle gap between them.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(DIV);
        lat = last_valid_cyc - prev_valid_cyc;
        check("t4_spacing", (lat >= NBITS * DIV - 1 && lat <= NBITS * DIV + 1), 1);
        drain("t4_b2b");
        last_good = 8'hFF;
        check("t4_data", o_data, last_good);

        // Reset during data bit 4 of 0x81, line left low across the release.
        b81 = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b81[i]);
        uart_rx = b81[4];
        repeat (HALF) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_outputs_in_reset", {o_data, o_valid, o_frame_err, o_parity_err, o_busy}, 12'h000);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        idle(2 * DIV);
        last_good = 8'h00;
        check("t5_no_partial", got_q.size(), 0);
        check("t5_no_frame_err", fe_cnt, fe_exp);
        check("t5_idle_after_reset", o_busy, 0);
        check("t5_data_cleared", o_data, last_good);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(DIV);
        drain("t5_after_reset");
        last_good = 8'h3C;
        check("t5_data", o_data, last_good);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_bits(8'h07, 1'b1, 1'b1);
        idle(DIV);
        drain("p1_good_parity");
        last_good = 8'h07;
        check("p1_data", o_data, last_good);
        send_bits(8'h3C, 1'b0, 1'b1);
        send_bits(8'h07, 1'b0, 1'b1);
        idle(DIV);
        pe_exp++;
        check("p2_parity_err", pe_cnt, pe_exp);
        check("p2_no_valid", got_q.size(), 1);
        exp_q.push_back(8'h3C);
        drain("p2_prior_good");
        last_good = 8'h3C;
        check("p2_data_kept", o_data, last_good);
`endif

        // Random bytes, some with a bad stop bit and random break length.
        for (int n = 0; n < 10; n++) begin
            rb  = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            if (bad) begin
                send_frame(rb, 1'b0);
                fe_exp++;
                hold = $urandom_range(0, 2 * DIV);
                repeat (hold) @(negedge clk);
                idle(4 + $urandom_range(0, DIV));
            end else begin
                exp_q.push_back(rb);
                last_good = rb;
                send_frame(rb, 1'b1);
                idle($urandom_range(0, DIV));
            end
            drain("rand_byte");
            check("rand_frame_err", fe_cnt, fe_exp);
            check("rand_data_held", o_data, last_good);
        end

        idle(DIV);
        check("final_no_overlap", overlap_cnt, 0);
        check("final_parity_errs", pe_cnt, pe_exp);
        check("final_frame_errs", fe_cnt, fe_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
